// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Holds NUM_STAGES reset domains in reset until the PLL has been locked for
//   HOLD_CYCLES cycles. It then releases the domains one at a time, in
//   ascending index order, STAGE_DELAY cycles apart. Lock loss or a soft
//   request after release has started aborts the sequence back to HOLD and
//   bumps a saturating restart counter.
// Ports
//   clock          : system clock, rising edge
//   reset          : asynchronous active-high master reset
//   pll_locked     : raw PLL lock level (asynchronous, synchronized here)
//   soft_reset_req : one-cycle synchronous request to rerun the sequence
//   stage_reset    : per-domain active-high resets, bit 0 released first
//   seq_done       : high while every domain is released
//   seq_state      : 0 HOLD, 1 RELEASE, 2 RUN
//   restart_count  : aborts from RELEASE/RUN back to HOLD, saturates at 255
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  seq_done,
  output logic [1:0]            seq_state,
  output logic [7:0]            restart_count
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_STAGES);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  logic                  sync1_q, lock_s_q;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                  seq_done_q, seq_done_d;
  logic [7:0]            restart_q, restart_d;
  logic                  abort;

  // Two-flop synchronizer; only lock_s_q is trusted downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  assign abort = !lock_s_q || soft_reset_req;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    seq_done_d    = seq_done_q;
    restart_d     = restart_q;
    case (state_q)
      S_HOLD: begin
        if (abort) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d          = S_RELEASE;
          cnt_d            = '0;
          stage_reset_d[0] = 1'b0;
          idx_d            = IW'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE, S_RUN: begin
        // Abort wins over any release due on the same edge.
        if (abort) begin
          state_d       = S_HOLD;
          cnt_d         = '0;
          idx_d         = '0;
          stage_reset_d = '1;
          seq_done_d    = 1'b0;
          if (restart_q != 8'hFF) restart_d = restart_q + 8'd1;
        end else if (state_q == S_RELEASE) begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d                = '0;
            stage_reset_d[idx_q] = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
              idx_d      = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // Unused encoding: fall back to a safe HOLD.
        state_d       = S_HOLD;
        cnt_d         = '0;
        idx_d         = '0;
        stage_reset_d = '1;
        seq_done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      seq_done_q    <= 1'b0;
      restart_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      seq_done_q    <= seq_done_d;
      restart_q     <= restart_d;
    end
  end

  assign stage_reset   = stage_reset_q;
  assign seq_done      = seq_done_q;
  assign seq_state     = state_q;
  assign restart_count = restart_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer with default parameters. Stimulus
//   pushes hand-computed expected outputs tagged with an edge number
//   (edge 1 = first rising edge after reset deasserts); a monitor samples on
//   each falling edge and compares against the queue head.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic [3:0] stage_reset;
  logic       seq_done;
  logic [1:0] seq_state;
  logic [7:0] restart_count;

  reset_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .stage_reset   (stage_reset),
    .seq_done      (seq_done),
    .seq_state     (seq_state),
    .restart_count (restart_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         rel;
    logic [3:0] sr;
    logic       done;
    logic [1:0] st;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  int   base = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input int e, input logic [3:0] sr, input logic done,
                      input logic [1:0] st, input logic [7:0] rc);
    exp_t x;
    x.cyc = base + e; x.rel = e; x.sr = sr; x.done = done; x.st = st; x.rc = rc;
    sb.push_back(x);
  endtask

  // Leaves us just after edge n-1, so inputs set next are sampled at edge n.
  task automatic before_edge(input int n);
    while (cyc < base + n - 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input logic pll);
    @(posedge clock);
    #1;
    reset = 1'b1;
    pll_locked = pll;
    soft_reset_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    base = cyc;
  endtask

  // Monitor: compare every expectation whose edge has been reached.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front();
        vectors++;
        if (x.cyc < cyc) begin
          miscompares++;
          $display("FAIL edge%0d: sample missed, got none, want sr=%b done=%b st=%0d rc=%0d",
                   x.rel, x.sr, x.done, x.st, x.rc);
        end else if ({stage_reset, seq_done, seq_state, restart_count} !==
                     {x.sr, x.done, x.st, x.rc}) begin
          miscompares++;
          $display("FAIL edge%0d: got sr=%b done=%b st=%0d rc=%0d, want sr=%b done=%b st=%0d rc=%0d",
                   x.rel, stage_reset, seq_done, seq_state, restart_count,
                   x.sr, x.done, x.st, x.rc);
        end
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    // Run A: lock held through reset, nominal release, soft restart in RUN,
    // lock loss mid-RELEASE, then lock loss plus soft request on one edge.
    do_reset(1'b1);
    push(0,   4'hF, 0, 0, 0);
    push(17,  4'hF, 0, 0, 0);
    push(18,  4'hE, 0, 1, 0);
    push(25,  4'hE, 0, 1, 0);
    push(26,  4'hC, 0, 1, 0);
    push(34,  4'h8, 0, 1, 0);
    push(41,  4'h8, 0, 1, 0);
    push(42,  4'h0, 1, 2, 0);
    push(49,  4'h0, 1, 2, 0);
    push(50,  4'hF, 0, 0, 1);
    push(65,  4'hF, 0, 0, 1);
    push(66,  4'hE, 0, 1, 1);
    push(74,  4'hC, 0, 1, 1);
    push(82,  4'h8, 0, 1, 1);
    push(90,  4'h0, 1, 2, 1);
    push(100, 4'hF, 0, 0, 2);
    push(116, 4'hE, 0, 1, 2);
    push(124, 4'hC, 0, 1, 2);
    push(128, 4'hC, 0, 1, 2);
    push(129, 4'hF, 0, 0, 3);
    push(146, 4'hF, 0, 0, 3);
    push(147, 4'hE, 0, 1, 3);
    push(155, 4'hC, 0, 1, 3);
    push(158, 4'hC, 0, 1, 3);
    push(159, 4'hF, 0, 0, 4);
    push(165, 4'hF, 0, 0, 4);
    before_edge(50);  soft_reset_req = 1'b1;
    before_edge(51);  soft_reset_req = 1'b0;
    before_edge(100); soft_reset_req = 1'b1;
    before_edge(101); soft_reset_req = 1'b0;
    before_edge(127); pll_locked = 1'b0;
    before_edge(130); pll_locked = 1'b1;
    before_edge(157); pll_locked = 1'b0;
    before_edge(159); soft_reset_req = 1'b1;
    before_edge(160); soft_reset_req = 1'b0; pll_locked = 1'b1;
    before_edge(167);

    // Run B: 3-cycle lock glitch in HOLD with counter at 10 restarts the count.
    do_reset(1'b1);
    push(0,  4'hF, 0, 0, 0);
    push(12, 4'hF, 0, 0, 0);
    push(18, 4'hF, 0, 0, 0);
    push(32, 4'hF, 0, 0, 0);
    push(33, 4'hE, 0, 1, 0);
    before_edge(13); pll_locked = 1'b0;
    before_edge(16); pll_locked = 1'b1;
    before_edge(35);

    // Run C: 300 soft restarts right after each first release, then settle in
    // RUN and assert reset between edges.
    do_reset(1'b1);
    push(0,    4'hF, 0, 0, 0);
    push(18,   4'hE, 0, 1, 0);
    push(19,   4'hF, 0, 0, 1);
    push(4320, 4'hF, 0, 0, 254);
    push(4336, 4'hE, 0, 1, 254);
    push(4337, 4'hF, 0, 0, 255);
    push(4354, 4'hF, 0, 0, 255);
    push(5101, 4'hE, 0, 1, 255);
    push(5102, 4'hF, 0, 0, 255);
    push(5142, 4'h0, 1, 2, 255);
    push(5149, 4'h0, 1, 2, 255);
    push(5150, 4'hF, 0, 0, 0);
    for (int j = 0; j < 300; j++) begin
      before_edge(19 + 17 * j); soft_reset_req = 1'b1;
      before_edge(20 + 17 * j); soft_reset_req = 1'b0;
    end
    before_edge(5151);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL edge%0d: got unchecked, want sr=%b done=%b st=%0d rc=%0d",
               x.rel, x.sr, x.done, x.st, x.rc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
